// File: rtl/musa_dmem_pkg.sv
// Shared definitions for the MUSA data-memory arbiter slice.
//   PRIO_*      priority mode encodings for PRIORITY_MODE
//   CH_*        fixed channel assignments (core, LCD reader)
//   MAX_CH      upper bound on requester count
//   MAX_RD_LAT  upper bound on RAM read latency
//   rd_tag_t    one read-tag pipeline stage {valid, channel index}
package musa_dmem_pkg;

    localparam int unsigned PRIO_RR    = 0;
    localparam int unsigned PRIO_FIXED = 1;
    localparam int unsigned CH_CORE    = 0;
    localparam int unsigned CH_LCD     = 1;
    localparam int unsigned MAX_CH     = 8;
    localparam int unsigned MAX_RD_LAT = 3;
    localparam int unsigned CH_IDX_W   = $clog2(MAX_CH);

    typedef logic [CH_IDX_W-1:0] ch_idx_t;

    typedef struct packed {
        logic    valid;
        ch_idx_t ch;
    } rd_tag_t;

    // True when more than one requester is active this cycle.
    function automatic logic multi_req(input logic [MAX_CH-1:0] req);
        return $countones(req) > 1;
    endfunction

endpackage

// File: rtl/musa_rr_arbiter.sv
// Request arbiter: turns a request vector into a one-hot grant plus the
// granted index. Owns the round-robin pointer register.
//   clk, rst_n    clock, asynchronous active-low reset
//   req_i         per-channel request
//   gnt_o         one-hot grant (zero when nothing requests)
//   gnt_idx_o     index of the granted channel
//   gnt_valid_o   a grant exists this cycle
module musa_rr_arbiter
    import musa_dmem_pkg::*;
#(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned PRIORITY_MODE = PRIO_RR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req_i,
    output logic [NUM_CH-1:0] gnt_o,
    output ch_idx_t           gnt_idx_o,
    output logic              gnt_valid_o
);

    ch_idx_t ptr_q, ptr_d;

    // Search starts at the pointer (RR) or at index 0 (fixed); the first
    // asserted request encountered wins.
    always_comb begin
        int unsigned cand;
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        cand        = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (PRIORITY_MODE == PRIO_FIXED) begin
                cand = i;
            end else begin
                cand = 32'(ptr_q) + i;
                if (cand >= NUM_CH) cand = cand - NUM_CH;
            end
            if (!gnt_valid_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = ch_idx_t'(cand);
                gnt_valid_o = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (PRIORITY_MODE == PRIO_RR && gnt_valid_o) begin
            ptr_d = (32'(gnt_idx_o) == NUM_CH - 1) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/musa_dmem_arbiter.sv
// Multi-channel arbiter for the MUSA data memory port. Grants one requester
// per cycle, drives the synchronous RAM and tags reads through the RAM
// latency so read data comes back with a per-channel valid.
//   clk, rst_n       clock, asynchronous active-low reset
//   req_i/we_i       per-channel request and write(1)/read(0)
//   addr_i/wdata_i   per-channel address/data, ch k at [k*W +: W]
//   gnt_o            one-hot grant, same cycle as request
//   rvalid_o/rdata_o read-data valid for owning channel, RAM data passthrough
//   mem_*_o, mem_q_i RAM interface
//   conflict_o       saturating count of cycles with more than one request
module musa_dmem_arbiter
    import musa_dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned RD_LATENCY    = 1,
    parameter int unsigned PRIORITY_MODE = PRIO_RR
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            req_i,
    input  logic [NUM_CH-1:0]            we_i,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_CH-1:0]            gnt_o,
    output logic [NUM_CH-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]        rdata_o,
    output logic [ADDR_WIDTH-1:0]        mem_addr_o,
    output logic [DATA_WIDTH-1:0]        mem_wdata_o,
    output logic                         mem_wren_o,
    output logic                         mem_rden_o,
    input  logic [DATA_WIDTH-1:0]        mem_q_i,
    output logic [15:0]                  conflict_o
);

    logic [NUM_CH-1:0] gnt;
    ch_idx_t           gnt_idx;
    logic              gnt_valid;
    rd_tag_t           tag_d;
    rd_tag_t           tag_q [RD_LATENCY];
    logic [15:0]       conflict_q, conflict_d;

    musa_rr_arbiter #(
        .NUM_CH        (NUM_CH),
        .PRIORITY_MODE (PRIORITY_MODE)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    assign gnt_o = gnt;

    // Grant is one-hot, so at most one slice is selected.
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wren_o  = 1'b0;
        mem_rden_o  = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                mem_addr_o  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata_o = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                mem_wren_o  = we_i[i];
                mem_rden_o  = ~we_i[i];
            end
        end
    end

    always_comb begin
        tag_d.valid = gnt_valid & mem_rden_o;
        tag_d.ch    = gnt_idx;
    end

    always_comb begin
        conflict_d = conflict_q;
        if (multi_req(MAX_CH'(req_i)) && conflict_q != '1) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
            conflict_q <= '0;
        end else begin
            tag_q[0] <= tag_d;
            for (int unsigned i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        rvalid_o = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            rvalid_o[i] = tag_q[RD_LATENCY-1].valid && (32'(tag_q[RD_LATENCY-1].ch) == i);
        end
    end

    assign rdata_o    = mem_q_i;
    assign conflict_o = conflict_q;

endmodule

// File: tb/tb_musa_dmem_arbiter.sv
module tb_musa_dmem_arbiter;
    import musa_dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we;
    logic [15:0] addr;
    logic [63:0] wdata;

    // rr: round-robin, latency 1; fx: fixed priority, latency 1; l3: round-robin, latency 3
    logic [1:0]  rr_gnt, rr_rvalid, fx_gnt, fx_rvalid, l3_gnt, l3_rvalid;
    logic [31:0] rr_rdata, fx_rdata, l3_rdata, rr_wdata, fx_wdata, l3_wdata;
    logic [7:0]  rr_addr, fx_addr, l3_addr;
    logic        rr_wren, rr_rden, fx_wren, fx_rden, l3_wren, l3_rden;
    logic [31:0] rr_q, fx_q, l3_q, l3_s0, l3_s1;
    logic [15:0] rr_conf, fx_conf, l3_conf;
    logic [31:0] mem_rr [256];
    logic [31:0] mem_fx [256];
    logic [31:0] mem_l3 [256];

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    musa_dmem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_CH(2), .RD_LATENCY(1), .PRIORITY_MODE(PRIO_RR)) u_rr (
        .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(rr_gnt), .rvalid_o(rr_rvalid), .rdata_o(rr_rdata), .mem_addr_o(rr_addr),
        .mem_wdata_o(rr_wdata), .mem_wren_o(rr_wren), .mem_rden_o(rr_rden), .mem_q_i(rr_q),
        .conflict_o(rr_conf));

    musa_dmem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_CH(2), .RD_LATENCY(1), .PRIORITY_MODE(PRIO_FIXED)) u_fx (
        .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(fx_gnt), .rvalid_o(fx_rvalid), .rdata_o(fx_rdata), .mem_addr_o(fx_addr),
        .mem_wdata_o(fx_wdata), .mem_wren_o(fx_wren), .mem_rden_o(fx_rden), .mem_q_i(fx_q),
        .conflict_o(fx_conf));

    musa_dmem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_CH(2), .RD_LATENCY(3), .PRIORITY_MODE(PRIO_RR)) u_l3 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(l3_gnt), .rvalid_o(l3_rvalid), .rdata_o(l3_rdata), .mem_addr_o(l3_addr),
        .mem_wdata_o(l3_wdata), .mem_wren_o(l3_wren), .mem_rden_o(l3_rden), .mem_q_i(l3_q),
        .conflict_o(l3_conf));

    // Synchronous RAM models
    always @(posedge clk) begin
        if (rr_wren) mem_rr[rr_addr] <= rr_wdata;
        if (rr_rden) rr_q <= mem_rr[rr_addr];
        if (fx_wren) mem_fx[fx_addr] <= fx_wdata;
        if (fx_rden) fx_q <= mem_fx[fx_addr];
        if (l3_wren) mem_l3[l3_addr] <= l3_wdata;
        if (l3_rden) l3_s0 <= mem_l3[l3_addr];
        l3_s1 <= l3_s0;
        l3_q  <= l3_s1;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = '0;
        we  = '0;
        repeat (n) next_cycle();
    endtask

    task automatic set_ch(input int ch, input logic r, input logic w, input logic [7:0] a, input logic [31:0] d);
        req[ch]            = r;
        we[ch]             = w;
        addr[ch*8 +: 8]    = a;
        wdata[ch*32 +: 32] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++; if (rr_gnt !== 2'b00) $display("FAIL reset_gnt: got %b expected 00", rr_gnt); else passed++;
        total++; if (rr_wren !== 1'b0 || rr_rden !== 1'b0) $display("FAIL reset_en: got wren=%b rden=%b expected 0/0", rr_wren, rr_rden); else passed++;
        total++; if (rr_addr !== 8'h00) $display("FAIL reset_addr: got %h expected 00", rr_addr); else passed++;
        total++; if (rr_rvalid !== 2'b00) $display("FAIL reset_rvalid: got %b expected 00", rr_rvalid); else passed++;
        total++; if (rr_conf !== 16'h0000) $display("FAIL reset_conflict: got %h expected 0000", rr_conf); else passed++;
        total++; if (l3_rvalid !== 2'b00) $display("FAIL reset_l3_rvalid: got %b expected 00", l3_rvalid); else passed++;
        next_cycle();
    endtask

    task automatic test_rr_alternate();
        logic [1:0]  eg, ev;
        logic [31:0] ed;
        set_ch(CH_CORE, 1'b1, 1'b0, 8'h20, 32'h0);
        set_ch(CH_LCD,  1'b1, 1'b0, 8'h30, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
            total++; if (rr_gnt !== eg) $display("FAIL rr_gnt c%0d: got %b expected %b", i, rr_gnt, eg); else passed++;
            total++; if (rr_conf !== 16'(i)) $display("FAIL rr_conflict c%0d: got %0d expected %0d", i, rr_conf, i); else passed++;
            if (i > 0) begin
                ev = (i % 2 == 1) ? 2'b01 : 2'b10;
                ed = (i % 2 == 1) ? 32'hCAFE_0020 : 32'hCAFE_0030;
                total++; if (rr_rvalid !== ev || rr_rdata !== ed)
                    $display("FAIL rr_rdata c%0d: got %b/%h expected %b/%h", i, rr_rvalid, rr_rdata, ev, ed);
                else passed++;
            end
            next_cycle();
        end
        req = '0;
        @(negedge clk);
        total++; if (rr_gnt !== 2'b00) $display("FAIL rr_drop_gnt: got %b expected 00", rr_gnt); else passed++;
        total++; if (rr_rvalid !== 2'b10 || rr_rdata !== 32'hCAFE_0030)
            $display("FAIL rr_last_rdata: got %b/%h expected 10/cafe0030", rr_rvalid, rr_rdata);
        else passed++;
        total++; if (rr_conf !== 16'd4) $display("FAIL rr_conflict_end: got %0d expected 4", rr_conf); else passed++;
        next_cycle();
        idle(4);
    endtask

    task automatic test_fixed();
        set_ch(CH_CORE, 1'b1, 1'b0, 8'h20, 32'h0);
        set_ch(CH_LCD,  1'b1, 1'b0, 8'h30, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (fx_gnt !== 2'b01) $display("FAIL fx_gnt c%0d: got %b expected 01", i, fx_gnt); else passed++;
            next_cycle();
        end
        req[CH_CORE] = 1'b0;
        @(negedge clk);
        total++; if (fx_gnt !== 2'b10) $display("FAIL fx_gnt_ch1: got %b expected 10", fx_gnt); else passed++;
        total++; if (fx_addr !== 8'h30) $display("FAIL fx_addr_ch1: got %h expected 30", fx_addr); else passed++;
        next_cycle();
        idle(4);
    endtask

    task automatic test_single_read();
        req = '0; we = '0;
        set_ch(CH_CORE, 1'b1, 1'b0, 8'h10, 32'h0);
        @(negedge clk);
        total++; if (rr_gnt !== 2'b01) $display("FAIL single_gnt: got %b expected 01", rr_gnt); else passed++;
        total++; if (rr_rden !== 1'b1 || rr_wren !== 1'b0) $display("FAIL single_en: got rden=%b wren=%b expected 1/0", rr_rden, rr_wren); else passed++;
        total++; if (rr_addr !== 8'h10) $display("FAIL single_addr: got %h expected 10", rr_addr); else passed++;
        next_cycle();
        req = '0;
        @(negedge clk);
        total++; if (rr_rvalid !== 2'b01) $display("FAIL single_rvalid: got %b expected 01", rr_rvalid); else passed++;
        total++; if (rr_rdata !== 32'hCAFE_0010) $display("FAIL single_rdata: got %h expected cafe0010", rr_rdata); else passed++;
        next_cycle();
        total++; if (rr_rvalid !== 2'b00) $display("FAIL single_rvalid_clear: got %b expected 00", rr_rvalid); else passed++;
        idle(4);
    endtask

    task automatic test_lat3_mix();
        req = '0; we = '0;
        set_ch(CH_LCD, 1'b1, 1'b0, 8'h40, 32'h0);                  // t: ch1 read
        @(negedge clk);
        total++; if (l3_gnt !== 2'b10) $display("FAIL l3_gnt_t0: got %b expected 10", l3_gnt); else passed++;
        next_cycle();
        req = '0;
        set_ch(CH_CORE, 1'b1, 1'b1, 8'h50, 32'h1234_5678);         // t+1: ch0 write
        @(negedge clk);
        total++; if (l3_gnt !== 2'b01 || l3_wren !== 1'b1 || l3_rden !== 1'b0)
            $display("FAIL l3_write: got gnt=%b wren=%b rden=%b expected 01/1/0", l3_gnt, l3_wren, l3_rden);
        else passed++;
        next_cycle();
        set_ch(CH_CORE, 1'b1, 1'b0, 8'h50, 32'h0);                 // t+2: ch0 read
        next_cycle();
        req = '0;
        @(negedge clk);                                             // t+3
        total++; if (l3_rvalid !== 2'b10 || l3_rdata !== 32'hCAFE_0040)
            $display("FAIL l3_t3: got %b/%h expected 10/cafe0040", l3_rvalid, l3_rdata);
        else passed++;
        next_cycle();
        @(negedge clk);                                             // t+4
        total++; if (l3_rvalid !== 2'b00) $display("FAIL l3_t4: got %b expected 00", l3_rvalid); else passed++;
        next_cycle();
        @(negedge clk);                                             // t+5
        total++; if (l3_rvalid !== 2'b01 || l3_rdata !== 32'h1234_5678)
            $display("FAIL l3_t5: got %b/%h expected 01/12345678", l3_rvalid, l3_rdata);
        else passed++;
        next_cycle();
        idle(4);
    endtask

    task automatic test_reset_mid_read();
        req = '0; we = '0;
        set_ch(CH_CORE, 1'b1, 1'b0, 8'h60, 32'h0);
        @(negedge clk);
        total++; if (rr_gnt !== 2'b01) $display("FAIL midrst_gnt: got %b expected 01", rr_gnt); else passed++;
        next_cycle();
        req = '0;
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (rr_rvalid !== 2'b00) $display("FAIL midrst_rvalid_in_reset: got %b expected 00", rr_rvalid); else passed++;
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (rr_rvalid !== 2'b00 || l3_rvalid !== 2'b00)
                $display("FAIL midrst_rvalid c%0d: got rr=%b l3=%b expected 00/00", i, rr_rvalid, l3_rvalid);
            else passed++;
            next_cycle();
        end
        set_ch(CH_CORE, 1'b1, 1'b0, 8'h01, 32'h0);
        set_ch(CH_LCD,  1'b1, 1'b0, 8'h02, 32'h0);
        @(negedge clk);
        total++; if (rr_gnt !== 2'b01) $display("FAIL midrst_tie_rr: got %b expected 01", rr_gnt); else passed++;
        total++; if (l3_gnt !== 2'b01) $display("FAIL midrst_tie_l3: got %b expected 01", l3_gnt); else passed++;
        total++; if (rr_conf !== 16'd0) $display("FAIL midrst_conflict: got %0d expected 0", rr_conf); else passed++;
        next_cycle();
        idle(2);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_rr[i] = {16'hCAFE, 16'(i)};
            mem_fx[i] = {16'hCAFE, 16'(i)};
            mem_l3[i] = {16'hCAFE, 16'(i)};
        end
        test_reset();
        test_rr_alternate();
        test_fixed();
        test_single_read();
        test_lat3_mix();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
